// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register for a 5-stage RV32I core.
// Keeps one instruction-memory request in flight and parks early responses in a one-entry buffer.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_F,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PCPlus4_D,
    output logic            valid_D,
    output logic            fetch_busy
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [XLEN-1:0] pc_f_r;
    logic [XLEN-1:0] req_pc_r;
    logic [31:0]     hold_instr_r;
    logic [XLEN-1:0] hold_pc_r;
    logic            hold_full_r;
    logic            fetch_busy_r;
    logic [31:0]     instr_d_r;
    logic [XLEN-1:0] pc_d_r;
    logic [XLEN-1:0] pcplus4_d_r;
    logic            valid_d_r;

    logic            handshake_s;
    logic            load_rsp_s;
    logic            capture_s;
    logic            release_s;
    logic [XLEN-1:0] target_s;

    assign imem_req_valid = (state_r == S_REQ) && !stall_F && !reset;
    assign imem_req_addr  = pc_f_r;
    assign handshake_s    = imem_req_valid && imem_req_ready;
    assign target_s       = PCTarget_E & ALIGN_MASK;

    // A response that cannot enter IF/ID this cycle (stall or flush) is parked in the hold buffer.
    assign load_rsp_s = (state_r == S_WAIT) && imem_rsp_valid && !PCSrc_E && !stall_D && !flush_D;
    assign capture_s  = (state_r == S_WAIT) && imem_rsp_valid && !PCSrc_E && (stall_D || flush_D);
    assign release_s  = (state_r == S_HOLD) && hold_full_r && !PCSrc_E && !stall_D && !flush_D;

    assign instr_D    = instr_d_r;
    assign PC_D       = pc_d_r;
    assign PCPlus4_D  = pcplus4_d_r;
    assign valid_D    = valid_d_r;
    assign fetch_busy = fetch_busy_r;

    // Next-state selection; a redirect with a request still in flight must drain its response.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_REQ: begin
                if (handshake_s) begin
                    state_nxt_s = PCSrc_E ? S_DRAIN : S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = capture_s ? S_HOLD : S_REQ;
                end else if (PCSrc_E) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (PCSrc_E || release_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_REQ;
        endcase
    end

    // Fetch state, PC, outstanding-request PC and hold buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_REQ;
            fetch_busy_r <= 1'b0;
            pc_f_r       <= RESET_PC;
            req_pc_r     <= {XLEN{1'b0}};
            hold_instr_r <= NOP_INSTR;
            hold_pc_r    <= {XLEN{1'b0}};
            hold_full_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fetch_busy_r <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_DRAIN);
            if (PCSrc_E) begin
                pc_f_r <= target_s;
            end else if (handshake_s) begin
                pc_f_r <= pc_f_r + PC_STEP;
            end
            if (handshake_s) begin
                req_pc_r <= pc_f_r;
            end
            if (capture_s) begin
                hold_instr_r <= imem_rsp_data;
                hold_pc_r    <= req_pc_r;
                hold_full_r  <= 1'b1;
            end else if ((state_r == S_HOLD) && (PCSrc_E || release_s)) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    // IF/ID register: flush beats stall, stall beats a fresh load, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_r   <= NOP_INSTR;
            pc_d_r      <= {XLEN{1'b0}};
            pcplus4_d_r <= {XLEN{1'b0}};
            valid_d_r   <= 1'b0;
        end else if (PCSrc_E || flush_D) begin
            instr_d_r <= NOP_INSTR;
            valid_d_r <= 1'b0;
        end else if (load_rsp_s) begin
            instr_d_r   <= imem_rsp_data;
            pc_d_r      <= req_pc_r;
            pcplus4_d_r <= req_pc_r + PC_STEP;
            valid_d_r   <= 1'b1;
        end else if (release_s) begin
            instr_d_r   <= hold_instr_r;
            pc_d_r      <= hold_pc_r;
            pcplus4_d_r <= hold_pc_r + PC_STEP;
            valid_d_r   <= 1'b1;
        end else if (!stall_D) begin
            instr_d_r <= NOP_INSTR;
            valid_d_r <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage and IF/ID pipeline register for the 5-stage RV32I core.
- Consumes the hazard unit's stall_F, stall_D, flush_D and PCSrc_E, and drives the instruction-memory request/response interface.
- Tolerates variable memory latency with one outstanding request and a one-entry hold buffer.
- Discards stale responses after a branch or jump redirect.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stall_F  in  1  hazard unit: hold PC, issue no new request
stall_D  in  1  hazard unit: hold IF/ID register
flush_D  in  1  hazard unit: clear IF/ID to bubble
PCSrc_E  in  1  branch/jump taken in EX; redirect fetch
PCTarget_E  in  XLEN  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (word-aligned)
imem_rsp_valid  in  1  response data valid; one per accepted request, in order
imem_rsp_data  in  32  fetched instruction
instr_D  out  32  IF/ID instruction
PC_D  out  XLEN  IF/ID PC
PCPlus4_D  out  XLEN  IF/ID PC+4
valid_D  out  1  IF/ID holds a real instruction
fetch_busy  out  1  request outstanding or drain in progress (status/perf)

Behaviour:
- Reset: state=REQ, PC_F=RESET_PC, imem_req_valid=0 during the reset cycle, imem_req_addr=RESET_PC, instr_D=NOP_INSTR, PC_D=0, PCPlus4_D=0, valid_D=0, hold buffer empty, fetch_busy=0. Reset mid-request abandons it; the system resets memory concurrently.
- Registers: PC_F; reqPC (PC of the outstanding request); hold buffer {instr, pc, full}; IF/ID register.
- States: REQ, WAIT, HOLD, DRAIN.
- REQ:
  - imem_req_valid = !stall_F; imem_req_addr = PC_F.
  - On handshake (valid&&ready): reqPC<=PC_F, PC_F<=PC_F+4, go to WAIT.
  - Address may change or valid may drop before acceptance (SRAM wrapper tolerates retraction).
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid and !stall_D: IF/ID <= {rsp_data, reqPC, reqPC+4, valid=1}; go to REQ.
  - On imem_rsp_valid and stall_D: capture into hold buffer; go to HOLD.
- HOLD: when stall_D=0, move buffer into IF/ID with valid=1, clear buffer, go to REQ.
- IF/ID when not loaded by the above: if stall_D, hold all fields; otherwise load bubble (instr=NOP_INSTR, valid=0, PC fields unchanged).
- Redirect (PCSrc_E=1), next-cycle effects:
  - PC_F<=PCTarget_E; IF/ID cleared to bubble (flush_D is asserted by the hazard unit in the same cycle).
  - REQ with handshake firing this cycle: request is stale; go to DRAIN.
  - REQ without handshake: stay REQ.
  - WAIT with rsp_valid this cycle: drop response; go to REQ.
  - WAIT without response: go to DRAIN.
  - HOLD: discard buffer; go to REQ.
  - DRAIN: stay DRAIN.
- DRAIN: imem_req_valid=0; the next imem_rsp_valid is discarded and never reaches IF/ID; then go to REQ.
- Priority: reset > PCSrc_E/flush_D > stall_D > normal load. flush_D+stall_D in the same cycle: flush wins and IF/ID becomes a bubble.
- stall_F alone never drops an outstanding response; the response is held via stall_D/HOLD.
- fetch_busy = (state==WAIT || state==DRAIN).
- Arithmetic: PC+4 wraps modulo 2^XLEN; PCTarget_E[1:0] forced to 0 on load.
- Throughput: at most one instruction per 2 cycles (REQ→WAIT→REQ with 1-cycle memory).

Test Plan:
- Reset, zero-wait memory returning instr = 0x00500093 + addr: accepted addresses 0x0,0x4,0x8; valid_D pulses with PC_D=0x0,0x4,0x8; PCPlus4_D=PC_D+4.
- Response arrives while stall_D=1 for 3 cycles: state HOLD; IF/ID unchanged for 3 cycles; next cycle instr_D=held data, valid_D=1; no extra request issued during HOLD.
- PCSrc_E=1, PCTarget_E=0x100 while in WAIT with 4-cycle memory latency: state→DRAIN; late response for 0x8 never appears (valid_D stays 0); next request address 0x100.
- PCSrc_E=1 with stall_D=1 (load-use and branch together): next cycle valid_D=0, instr_D=0x00000013; next request address = target.
- PCTarget_E=0xFFFFFFFC: fetches 0xFFFFFFFC then 0x00000000 (wrap); PCTarget_E=0x102 fetches 0x100.
- reset asserted while in WAIT: next cycle valid_D=0, instr_D=0x13, imem_req_addr=RESET_PC, state REQ.
